traffic_light_monitor: RTL
==========================

// Module: traffic_light_monitor
// PURPOSE
//  Receive-side checker for the traffic light controller's lamp outputs (MG..SR, pedLight).
//  Synchronises the lamps into clk, glitch-filters them and decodes them into the controller's phase code.
//  Tracks the legal phase sequence and raises sticky safety/sequence/timeout flags.
//  Counts completed cycles and pedestrian phases. Sits beside the controller for bring-up and runtime checking.
// PARAMETERS
//  TIMEOUT_CYCLES  1000  max clk cycles in one accepted phase before err_timeout
//  CNT_W           16    width of cycle_count / ped_count
// PORTS
//  clk          in   1      single clock; all logic on rising edge
//  reset        in   1      asynchronous, active-high reset
//  MG,MY,MR     in   1 ea   main-street lamps (asynchronous to clk)
//  SG,SY,SR     in   1 ea   side-street lamps (asynchronous to clk)
//  pedLight     in   1      pedestrian lamp (asynchronous to clk)
//  clear_err    in   1      synchronous clear of all sticky error flags
//  phase        out  3      accepted phase: GR=0 YR=1 RR1=2 RG=3 RY=4 RR2=5 PED=6 INVALID=7
//  phase_valid  out  1      1 = tracker locked to the sequence (TRACK state)
//  err_conflict out  1      sticky: conflicting lamps seen
//  err_sequence out  1      sticky: illegal transition or malformed pattern
//  err_timeout  out  1      sticky: phase dwell reached TIMEOUT_CYCLES
//  cycle_count  out  CNT_W  completed cycles, saturating
//  ped_count    out  CNT_W  pedestrian phases entered, saturating
// BEHAVIOUR
//  Reset (async): sync flops=0, phase=7, phase_valid=0, all err_*=0, counts=0, dwell=0, FSM=WAIT_SYNC. Applies mid-operation.
//  Sync: each lamp passes through a 2-flop synchroniser (s1, s2).
//  Decode of s2 (one lamp per street):
//   MG&SR=GR, MY&SR=YR, MR&SG=RG, MR&SY=RY (each with pedLight=0).
//   MR&SR&!pedLight=RR; MR&SR&pedLight=PED. Anything else=INVALID.
//  Filter: pat_q registers decode(s2). A change is accepted when decode(s2)==pat_q and differs from the current phase.
//  Filter latency: phase updates 3 edges after the edge that first samples a change into s1.
//  Filter rejection: patterns lasting 1 clk are dropped.
//  RR resolution: RR is phase 2 after YR, phase 5 after RY, and 2 when the predecessor is anything else.
//  FSM WAIT_SYNC: phase follows accepted decodes and phase_valid=0. No sequence checking.
//   Accepted GR -> TRACK, phase_valid=1.
//  FSM TRACK: legal successors are GR->YR->RR1->RG->RY->RR2->{GR|PED}, PED->GR.
//   Illegal accepted change: err_sequence=1, phase=new code, go to WAIT_SYNC.
//   Accepted INVALID: phase=7, err_sequence=1, go to WAIT_SYNC.
//  Conflict: evaluated on s2 every cycle, unfiltered, in either FSM state.
//   Trigger: (MG|MY)&(SG|SY), or pedLight&(MG|MY|SG|SY). Sets err_conflict on the next edge.
//  Counters (TRACK only): cycle_count+1 on accepted RR2->GR or PED->GR; ped_count+1 on accepted RR2->PED.
//   Both saturate at all-ones.
//  Dwell counter: cleared on every accepted change and in WAIT_SYNC. Otherwise increments in TRACK, saturating.
//   dwell==TIMEOUT_CYCLES-1 sets err_timeout on the next edge.
//  clear_err=1: all err_* cleared on the next edge. If a new error event occurs in the same cycle, set wins.
//  Outputs are registered; no combinational input-to-output paths.
// CONFIGURATION
//  TLMON_TIMEOUT_EN defined: dwell counter and err_timeout logic present, as described above.
//  TLMON_TIMEOUT_EN undefined: no dwell counter; err_timeout tied 0; TIMEOUT_CYCLES ignored.
// TESTING
//  1 Reset; drive GR,YR,RR,RG,RY,RR,GR, 10 clk each.
//    -> phase 0,1,2,3,4,5,0; phase_valid=1 from first GR; cycle_count=1; all err_*=0.
//  2 Run to RR2; drive MR,SR,pedLight 10 clk; then GR.
//    -> phase 6 then 0; ped_count=1; cycle_count+1 on PED->GR; no errors.
//  3 In GR, drive MG=0,MY=1 for 1 clk then restore.
//    -> phase stays 0; err_sequence=0; counts unchanged.
//  4 In GR, pulse SG=1 for 1 clk.
//    -> err_conflict=1 two edges later, stays 1. clear_err pulse -> 0 next edge.
//  5 Locked in GR; drive RG directly.
//    -> err_sequence=1, phase=3, phase_valid=0. Later GR -> phase_valid=1; err_sequence stays 1.
//  6 TIMEOUT_CYCLES=16, macro defined; hold GR 30 clk after lock.
//    -> err_timeout=1 after 16 dwell cycles. Macro undefined -> err_timeout stays 0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic light controller lamps: synchronise, glitch-filter, decode,
// track the phase sequence and raise sticky errors. Define TLMON_TIMEOUT_EN to build the dwell timeout.
module traffic_light_monitor #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MG,
    input  logic             MY,
    input  logic             MR,
    input  logic             SG,
    input  logic             SY,
    input  logic             SR,
    input  logic             pedLight,
    input  logic             clear_err,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] ped_count
);

    localparam logic [2:0] PH_GR  = 3'd0;
    localparam logic [2:0] PH_YR  = 3'd1;
    localparam logic [2:0] PH_RR1 = 3'd2;
    localparam logic [2:0] PH_RG  = 3'd3;
    localparam logic [2:0] PH_RY  = 3'd4;
    localparam logic [2:0] PH_RR2 = 3'd5;
    localparam logic [2:0] PH_PED = 3'd6;
    localparam logic [2:0] PH_INV = 3'd7;

    localparam logic [0:0] ST_WAIT_SYNC = 1'b0;
    localparam logic [0:0] ST_TRACK     = 1'b1;

    // Lamp vector layout: {MG, MY, MR, SG, SY, SR, pedLight}
    function automatic logic [2:0] decodeLamps(input logic [6:0] lamps);
        case (lamps)
            7'b100_001_0: return PH_GR;
            7'b010_001_0: return PH_YR;
            7'b001_001_0: return PH_RR1;
            7'b001_100_0: return PH_RG;
            7'b001_010_0: return PH_RY;
            7'b001_001_1: return PH_PED;
            default:      return PH_INV;
        endcase
    endfunction

    // All-red is ambiguous on its own; its meaning comes from the phase it follows.
    function automatic logic [2:0] resolveRedRed(input logic [2:0] pat, input logic [2:0] cur);
        if (pat != PH_RR1) return pat;
        case (cur)
            PH_YR:          return PH_RR1;
            PH_RY:          return PH_RR2;
            PH_RR1, PH_RR2: return cur;
            default:        return PH_RR1;
        endcase
    endfunction

    function automatic logic legalStep(input logic [2:0] from, input logic [2:0] to);
        case (from)
            PH_GR:   return to == PH_YR;
            PH_YR:   return to == PH_RR1;
            PH_RR1:  return to == PH_RG;
            PH_RG:   return to == PH_RY;
            PH_RY:   return to == PH_RR2;
            PH_RR2:  return (to == PH_GR) || (to == PH_PED);
            PH_PED:  return to == PH_GR;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic lampConflict(input logic [6:0] lamps);
        logic mainGo;
        logic sideGo;
        mainGo = lamps[6] | lamps[5];
        sideGo = lamps[3] | lamps[2];
        return (mainGo & sideGo) | (lamps[0] & (mainGo | sideGo));
    endfunction

    function automatic logic [CNT_W-1:0] satIncCnt(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    logic [6:0] lampRaw;
    logic [6:0] lampS1_p1;
    logic [6:0] lampS2_p2;
    logic [2:0] decoded_p2;
    logic [2:0] patQ_p3;
    logic [0:0] state;
    logic [2:0] candidate;
    logic       accept;
    logic       stepLegal;
    logic       conflictEvt;
    logic       sequenceEvt;
    logic       timeoutEvt;

    assign lampRaw = {MG, MY, MR, SG, SY, SR, pedLight};

    // Stage p1/p2: two-flop synchroniser; stage p3: pattern register for the stability filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lampS1_p1 <= '0;
            lampS2_p2 <= '0;
            patQ_p3   <= PH_INV;
        end else begin
            lampS1_p1 <= lampRaw;
            lampS2_p2 <= lampS1_p1;
            patQ_p3   <= decoded_p2;
        end
    end

    assign decoded_p2  = decodeLamps(lampS2_p2);
    assign candidate   = resolveRedRed(decoded_p2, phase);
    assign accept      = (decoded_p2 == patQ_p3) && (candidate != phase);
    assign stepLegal   = legalStep(phase, candidate);
    assign conflictEvt = lampConflict(lampS2_p2);
    assign sequenceEvt = accept && (state == ST_TRACK) && !stepLegal;

    // Stage p4: phase tracker and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_WAIT_SYNC;
            phase       <= PH_INV;
            cycle_count <= '0;
            ped_count   <= '0;
        end else if (accept) begin
            phase <= candidate;
            if (state == ST_WAIT_SYNC) begin
                if (candidate == PH_GR) state <= ST_TRACK;
            end else if (stepLegal) begin
                if (candidate == PH_GR) cycle_count <= satIncCnt(cycle_count);
                if (candidate == PH_PED) ped_count <= satIncCnt(ped_count);
            end else begin
                state <= ST_WAIT_SYNC;
            end
        end
    end

    assign phase_valid = (state == ST_TRACK);

`ifdef TLMON_TIMEOUT_EN
    localparam int DWELL_W = $clog2(TIMEOUT_CYCLES + 1);

    function automatic logic [DWELL_W-1:0] satIncDwell(input logic [DWELL_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    logic [DWELL_W-1:0] dwell;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell <= '0;
        end else if (accept || (state == ST_WAIT_SYNC)) begin
            dwell <= '0;
        end else begin
            dwell <= satIncDwell(dwell);
        end
    end

    assign timeoutEvt = (state == ST_TRACK) && (dwell == DWELL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_timeout <= 1'b0;
        else       err_timeout <= (err_timeout & ~clear_err) | timeoutEvt;
    end
`else
    assign timeoutEvt  = 1'b0;
    assign err_timeout = timeoutEvt;
`endif

    // Sticky flags: a new event in the clearing cycle wins over clear_err
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_conflict <= 1'b0;
            err_sequence <= 1'b0;
        end else begin
            err_conflict <= (err_conflict & ~clear_err) | conflictEvt;
            err_sequence <= (err_sequence & ~clear_err) | sequenceEvt;
        end
    end

endmodule
